// File: rtl/hazard_stall_controller.sv
// Load-use / memory-wait stall controller for the 5-stage MIPS pipeline.
// Mealy outputs; state, counters and the sticky timeout flag update on clk.
module hazard_stall_controller #(
    parameter int REG_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_EXCL   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEXMEMRead,
    input  logic [REG_W-1:0] IDEXRt,
    input  logic [REG_W-1:0] IFIDRs,
    input  logic [REG_W-1:0] IFIDRt,
    input  logic             IFIDUsesRt,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    output logic             PCWrite,
    output logic             IFDWrite,
    output logic             muxSelect,
    output logic             IFFlush,
    output logic             EXMEMWrite,
    output logic             memError,
    output logic [CNT_W-1:0] stallCount
);
    // state    | meaning
    // RUN      | normal flow, hazards and branches evaluated
    // LU_STALL | remaining load-use bubbles, lu_cnt = bubbles left incl. this one
    // MEM_WAIT | whole pipe frozen on data memory, ret_state resumes on memReady
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam int LU_W   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt, ret_state, ret_nxt, act;
    logic [LU_W-1:0]   lu_cnt, lu_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              haz, freeze, err_set;
    logic              pc_w, ifd_w, mux, flush, exm_w;

    assign haz = IDEXMEMRead && !((ZERO_EXCL != 0) && (IDEXRt == '0))
                 && ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));

    always_comb begin
        pc_w      = 1'b1;
        ifd_w     = 1'b1;
        mux       = 1'b0;
        flush     = 1'b0;
        exm_w     = 1'b1;
        state_nxt = state;
        ret_nxt   = ret_state;
        lu_nxt    = lu_cnt;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        act       = state;
        freeze    = 1'b0;

        // On release from MEM_WAIT the cycle is handled as the interrupted state
        if (state == MEM_WAIT) begin
            if (!memReady) begin
                freeze = 1'b1;
            end else begin
                act      = ret_state;
                wait_nxt = '0;
            end
        end else if (memReq && !memReady) begin
            freeze = 1'b1;
        end

        if (freeze) begin
            pc_w      = 1'b0;
            ifd_w     = 1'b0;
            exm_w     = 1'b0;
            state_nxt = MEM_WAIT;
            if (state != MEM_WAIT) begin
                ret_nxt  = state;
                wait_nxt = WAIT_W'(1);
            end else if (wait_cnt < WAIT_W'(MEM_TIMEOUT)) begin
                wait_nxt = wait_cnt + 1'b1;
            end
            err_set = (wait_nxt == WAIT_W'(MEM_TIMEOUT));
        end else if (act == LU_STALL) begin
            pc_w      = 1'b0;
            ifd_w     = 1'b0;
            mux       = 1'b1;
            lu_nxt    = lu_cnt - 1'b1;
            state_nxt = (lu_cnt == LU_W'(1)) ? RUN : LU_STALL;
        end else begin
            state_nxt = RUN;
            if (haz) begin
                pc_w  = 1'b0;
                ifd_w = 1'b0;
                mux   = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_nxt = LU_STALL;
                    lu_nxt    = LU_W'(LOAD_LAT - 1);
                end
            end else if (branchTaken) begin
                flush = 1'b1;
            end
        end
    end

    assign PCWrite    = reset | pc_w;
    assign IFDWrite   = reset | ifd_w;
    assign muxSelect  = !reset & mux;
    assign IFFlush    = !reset & flush;
    assign EXMEMWrite = reset | exm_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            ret_state  <= RUN;
            lu_cnt     <= '0;
            wait_cnt   <= '0;
            memError   <= 1'b0;
            stallCount <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lu_cnt    <= lu_nxt;
            wait_cnt  <= wait_nxt;
            if (err_set) memError <= 1'b1;
            if (!PCWrite && (stallCount != '1)) stallCount <= stallCount + 1'b1;
        end
    end
endmodule
